tx_engine: RTL and testbench

TX_ENGINE -- requirements
Module: tx_engine

---
 rtl/uart_pkg.sv | 26 ++
 rtl/bit_timer.sv | 38 +++
 rtl/tx_engine.sv | 134 +++++++++++++
 tb/tb_tx_engine.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, bit-period width, transmitter
// FSM states and the parity helper also used by the receive side.
package uart_pkg;

    localparam int FRAME_BITS = 11;
    localparam int K_W        = 19;

    // Index of the stop/pad slot that closes a frame.
    localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        SHIFT = 2'd2
    } tx_state_t;

    // Parity over the data bits actually on the line; odd parity inverts.
    function automatic logic parity_bit(input logic [7:0] data,
                                        input logic       eight,
                                        input logic       odd);
        logic p;
        p = eight ? (^data) : (^data[6:0]);
        return p ^ odd;
    endfunction

endpackage

// File: rtl/bit_timer.sv
// Bit-period down-counter. The period is captured on start; restart reloads
// the captured period without taking a new one. bit_done pulses for one
// cycle on the last cycle of each bit while counting is enabled.
module bit_timer
    import uart_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           restart,
    input  logic           en,
    input  logic [K_W-1:0] period,
    output logic           bit_done
);

    logic [K_W-1:0] per_q;
    logic [K_W-1:0] cnt_q;

    assign bit_done = en && (cnt_q == '0);

    // Capture period on start, count down while enabled, reload on each bit.
    always_ff @(posedge clk) begin
        // NOTE: state is written with <= so every register samples the values
        // from before the edge; = here would create order-dependent races.
        if (reset) begin
            per_q <= '0;
            cnt_q <= '0;
        end else if (start) begin
            per_q <= period;
            cnt_q <= period - K_W'(1);
        end else if (restart) begin
            cnt_q <= per_q - K_W'(1);
        end else if (en) begin
            cnt_q <= (cnt_q == '0) ? per_q - K_W'(1) : cnt_q - K_W'(1);
        end
    end

endmodule

// File: rtl/tx_engine.sv
// Double-buffered UART transmitter: 8-bit holding register feeding an 11-bit
// shift register, framed as start, 7/8 data bits LSB first, parity slot,
// stop, padded with 1s. Frame format and bit period are taken when a byte
// moves from holding to shifter.
// Optional build macro TX_BREAK_EN adds a BREAK input that forces the line
// low, blocks LOAD, freezes the FSM and restarts the current frame on release.
module tx_engine
    import uart_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
`ifdef TX_BREAK_EN
    input  logic           BREAK,
`endif
    input  logic           LOAD,
    input  logic [7:0]     OUT_PORT,
    input  logic           EIGHT,
    input  logic           PEN,
    input  logic           OHEL,
    input  logic [K_W-1:0] K,
    output logic           TX,
    output logic           TXRDY
);

    tx_state_t             state_q, state_d;
    logic [7:0]            hold_q;
    logic                  hold_full_q;
    logic [FRAME_BITS-1:0] shift_q;
    logic [3:0]            bit_cnt_q;
    logic                  brk;
    logic                  load_acc;
    logic                  bit_done;
    logic                  last_bit;
    logic [K_W-1:0]        k_eff;

`ifdef TX_BREAK_EN
    logic [FRAME_BITS-1:0] frame_q;   // copy of the current frame for restart
    assign brk = BREAK;
`else
    assign brk = 1'b0;
`endif

    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] data,
                                                          input logic       eight,
                                                          input logic       pen,
                                                          input logic       odd);
        logic par;
        par = pen ? parity_bit(data, eight, odd) : 1'b1;
        if (eight) return {1'b1, par, data, 1'b0};
        else       return {2'b11, par, data[6:0], 1'b0};
    endfunction

    assign TXRDY    = ~hold_full_q & ~brk;
    assign load_acc = LOAD & TXRDY;
    assign last_bit = (state_q == SHIFT) && bit_done && (bit_cnt_q == LAST_BIT);
    assign k_eff    = (K < K_W'(2)) ? K_W'(2) : K;
    assign TX       = brk ? 1'b0 : ((state_q == SHIFT) ? shift_q[0] : 1'b1);

    bit_timer u_bit_timer (
        .clk      (clk),
        .reset    (reset),
        .start    ((state_q == XFER) && !brk),
        .restart  (brk),
        .en       ((state_q == SHIFT) && !brk),
        .period   (k_eff),
        .bit_done (bit_done)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state: start a transfer whenever the holding register has a byte.
    always_comb begin
        // NOTE: the default assignment first keeps every path assigned, so
        // no latch is inferred for state_d.
        state_d = state_q;
        if (!brk) begin
            case (state_q)
                IDLE:    if (hold_full_q || load_acc) state_d = XFER;
                XFER:    state_d = SHIFT;
                SHIFT:   if (last_bit) state_d = (hold_full_q || load_acc) ? XFER : IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Holding register, shifter and bit counter.
    always_ff @(posedge clk) begin
        // NOTE: the data registers are reset too, so the line and buffers
        // come up in a defined all-ones state rather than holding stale data.
        if (reset) begin
            hold_q      <= 8'hFF;
            hold_full_q <= 1'b0;
            shift_q     <= '1;
            bit_cnt_q   <= '0;
`ifdef TX_BREAK_EN
            frame_q     <= '1;
`endif
        end else begin
            if (load_acc) begin
                hold_q      <= OUT_PORT;
                hold_full_q <= 1'b1;
            end
            if (brk) begin
`ifdef TX_BREAK_EN
                if (state_q == SHIFT) shift_q <= frame_q;
`endif
                bit_cnt_q <= '0;
            end else begin
                case (state_q)
                    XFER: begin
                        shift_q     <= build_frame(hold_q, EIGHT, PEN, OHEL);
`ifdef TX_BREAK_EN
                        frame_q     <= build_frame(hold_q, EIGHT, PEN, OHEL);
`endif
                        hold_full_q <= 1'b0;
                        bit_cnt_q   <= '0;
                    end
                    SHIFT: begin
                        if (bit_done && (bit_cnt_q != LAST_BIT)) begin
                            shift_q   <= {1'b1, shift_q[FRAME_BITS-1:1]};
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end
                    end
                    default: bit_cnt_q <= '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tx_engine.sv
// Self-checking bench for tx_engine: a transaction-level model predicts when
// each byte goes on the line and what its 11 slots are; a monitor decodes
// the serial line and compares against the expected-frame queue.
// Build with TX_BREAK_EN defined to also exercise the BREAK input.
module tb_tx_engine;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        LOAD = 1'b0;
    logic [7:0]  OUT_PORT = 8'h00;
    logic        EIGHT = 1'b1;
    logic        PEN = 1'b0;
    logic        OHEL = 1'b0;
    logic [18:0] K = 19'd4;
    logic        TX;
    logic        TXRDY;
`ifdef TX_BREAK_EN
    logic        BREAK = 1'b0;
`endif

    always #5 clk = ~clk;

    tx_engine dut (
        .clk      (clk),
        .reset    (reset),
`ifdef TX_BREAK_EN
        .BREAK    (BREAK),
`endif
        .LOAD     (LOAD),
        .OUT_PORT (OUT_PORT),
        .EIGHT    (EIGHT),
        .PEN      (PEN),
        .OHEL     (OHEL),
        .K        (K),
        .TX       (TX),
        .TXRDY    (TXRDY)
    );

    typedef struct {
        logic [10:0] bits;
        int          k;
        longint      start;
    } frame_t;

    frame_t exp_q[$];
    int     total = 0;
    int     bad = 0;
    longint cyc = 0;

    // model state
    bit          m_full = 0;
    logic [7:0]  m_data = 8'h00;
    longint      m_xfer = 0;
    longint      line_free = 0;
    frame_t      act;
    longint      act_end = -1;
    bit          started = 0;
    bit          brk_hold = 0;
    bit          restart_pend = 0;

    // monitor state
    bit          mon_in_frame = 0;
    frame_t      cur;
    int          idx = 0;
    int          ferr = 0;
    logic [10:0] got = '1;

    task automatic check(input string name, input bit ok, input longint act_v, input longint req_v);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act_v, req_v, cyc);
        end
    endtask

    // Frame from the rules: start 0, data LSB first, parity slot, rest 1.
    function automatic frame_t make_frame(input logic [7:0] d, input logic eight,
                                          input logic pen, input logic odd,
                                          input logic [18:0] kin, input longint st);
        frame_t f;
        int nbits;
        int ones;
        int slot;
        nbits = eight ? 8 : 7;
        ones = 0;
        f.bits = '1;
        f.bits[0] = 1'b0;
        slot = 1;
        for (int i = 0; i < nbits; i++) begin
            f.bits[slot] = d[i];
            ones += int'(d[i]);
            slot++;
        end
        if (pen) f.bits[slot] = odd ? (ones % 2 == 0) : (ones % 2 == 1);
        f.k = (kin < 19'd2) ? 2 : int'(kin);
        f.start = st;
        return f;
    endfunction

    // One clock cycle: check TXRDY, advance the model with this cycle's inputs.
    task automatic step();
        logic brk_in;
        logic ready_m;
`ifdef TX_BREAK_EN
        brk_in = BREAK;
`else
        brk_in = 1'b0;
`endif
        #1;
        ready_m = !m_full && !brk_in;
        if (started) check("txrdy", TXRDY === ready_m, longint'(TXRDY), longint'(ready_m));
        if (reset) begin
            m_full = 0;
            line_free = 0;
            act_end = -1;
            exp_q.delete();
            brk_hold = 0;
            restart_pend = 0;
            started = 1;
        end else if (brk_in) begin
            if (!brk_hold && cyc <= act_end) restart_pend = 1;
            brk_hold = 1;
            if (m_full && m_xfer <= cyc) m_xfer = cyc + 1;
        end else begin
            if (brk_hold) begin
                brk_hold = 0;
                if (restart_pend) begin
                    act.start = cyc;
                    act_end = cyc + 11 * act.k - 1;
                    line_free = act_end + 1;
                    exp_q.push_back(act);
                    restart_pend = 0;
                    if (m_full && m_xfer < line_free) m_xfer = line_free;
                end
            end
            if (m_full && cyc == m_xfer) begin
                act = make_frame(m_data, EIGHT, PEN, OHEL, K, cyc + 1);
                exp_q.push_back(act);
                act_end = cyc + 11 * act.k;
                line_free = act_end + 1;
                m_full = 0;
            end
            if (LOAD && ready_m) begin
                m_full = 1;
                m_data = OUT_PORT;
                m_xfer = (cyc + 1 > line_free) ? cyc + 1 : line_free;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        LOAD = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic load_byte(input logic [7:0] b);
        LOAD = 1'b1;
        OUT_PORT = b;
        step();
    endtask

    task automatic wait_idle(input int max);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || m_full || mon_in_frame || cyc < line_free) && n < max) begin
            step();
            n++;
        end
        check("drain", n < max, n, max);
    endtask

    // Monitor: decode the line at mid-cycle and compare whole frames.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                mon_in_frame = 0;
                continue;
            end
`ifdef TX_BREAK_EN
            if (BREAK) begin
                check("break_tx", TX === 1'b0, longint'(TX), 0);
                mon_in_frame = 0;
                continue;
            end
`endif
            if (mon_in_frame) begin
                if (idx % cur.k == 0) got[idx / cur.k] = TX;
                if (TX !== cur.bits[idx / cur.k]) ferr++;
                idx++;
                if (idx == 11 * cur.k) begin
                    check("frame", ferr == 0, longint'(got), longint'(cur.bits));
                    mon_in_frame = 0;
                end
            end else if (TX === 1'b0) begin
                check("unexpected_start", exp_q.size() != 0, exp_q.size(), 1);
                if (exp_q.size() != 0) begin
                    cur = exp_q.pop_front();
                    check("start_time", cyc == cur.start, cyc, cur.start);
                    got = '1;
                    got[0] = TX;
                    ferr = (TX !== cur.bits[0]) ? 1 : 0;
                    idx = 1;
                    mon_in_frame = 1;
                end
            end
        end
    end

    initial begin
        // reset state
        reset = 1'b1;
        run(3);
        reset = 1'b0;
        check("reset_tx", TX === 1'b1, longint'(TX), 1);
        check("reset_txrdy", TXRDY === 1'b1, longint'(TXRDY), 1);
        run(3);

        // 0x55, 8N1, K=109
        K = 19'd109; EIGHT = 1'b1; PEN = 1'b0; OHEL = 1'b0;
        load_byte(8'h55);
        wait_idle(3000);

        // parity: 0x07 odd then even
        K = 19'd3; PEN = 1'b1; OHEL = 1'b1;
        load_byte(8'h07);
        wait_idle(200);
        OHEL = 1'b0;
        load_byte(8'h07);
        wait_idle(200);

        // 7 data bits with even parity
        EIGHT = 1'b0; PEN = 1'b1; OHEL = 1'b0;
        load_byte(8'h81);
        wait_idle(200);

        // back-to-back frames, load while full is dropped
        EIGHT = 1'b1; PEN = 1'b0; K = 19'd3;
        load_byte(8'hA5);
        run(5);
        load_byte(8'h3C);
        load_byte(8'hFF);
        wait_idle(300);

        // LOAD in the transfer cycle is ignored
        load_byte(8'h11);
        load_byte(8'h22);
        wait_idle(200);

        // K below 2 clamps to 2
        K = 19'd0;
        load_byte(8'hC3);
        wait_idle(200);
        K = 19'd1;
        load_byte(8'h5A);
        wait_idle(200);

        // reset during bit 4 aborts the frame
        K = 19'd4;
        load_byte(8'h96);
        run(2);
        begin
            longint target;
            int n;
            target = act.start + 4 * act.k + 1;
            n = 0;
            while (cyc < target && n < 100) begin step(); n++; end
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_tx", TX === 1'b1, longint'(TX), 1);
        check("abort_txrdy", TXRDY === 1'b1, longint'(TXRDY), 1);
        run(60);
        check("abort_no_frame", exp_q.size() == 0 && !mon_in_frame, exp_q.size(), 0);

`ifdef TX_BREAK_EN
        // break mid-frame, then the frame is resent in full
        K = 19'd8; EIGHT = 1'b1; PEN = 1'b1; OHEL = 1'b1;
        load_byte(8'h5A);
        run(22);
        BREAK = 1'b1;
        run(2000);
        BREAK = 1'b0;
        wait_idle(500);
`endif

        // randomized traffic with configuration changing mid-frame
        for (int i = 0; i < 3000; i++) begin
            if ($urandom % 8 == 0) begin
                LOAD = 1'b1;
                OUT_PORT = 8'($urandom);
            end
            if ($urandom % 16 == 0) {EIGHT, PEN, OHEL} = 3'($urandom);
            K = 19'($urandom_range(0, 5));
            step();
        end
        wait_idle(2000);
        check("queue_empty", exp_q.size() == 0, exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
